ga20_sample_fetch: RTL and testbench
====================================

Name: ga20_sample_fetch

Overview:
- Responder side of the GA20 sample-ROM port. Serves byte reads for each `sample_index`/`sample_addr` pair the GA20 core presents.
- Holds one 8-byte line per channel (4 lines total) and refills lines from SDRAM through a single-outstanding 64-bit read handshake.
- Sits between the GA20 core and the SDRAM arbiter port assigned to sound ROM.

Parameters:
- SDR_AW, 25, SDRAM byte-address width.
- SDR_BASE, 25'h0, SDRAM byte offset of sample ROM region.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sample_rd  in  1  read request qualifier; lookup only when 1.
- sample_index  in  3  GA20 step; channel = sample_index[2:1].
- sample_addr  in  20  requested sample byte address.
- sample_valid  out  1  registered; 1 = sample_din holds the byte for the previous cycle's request.
- sample_din  out  8  registered sample byte.
- invalidate  in  1  clears all line valid bits (ROM reload).
- sdr_req  out  1  fill request, held high until sdr_rdy.
- sdr_addr  out  SDR_AW  8-byte-aligned fill byte address.
- sdr_rdy  in  1  one-cycle pulse; sdr_data valid.
- sdr_data  in  64  fill data, little-endian (byte k = bits 8k+7:8k).
- busy  out  1  fill engine not IDLE.

Behaviour:
- Reset values: sample_valid=0, sample_din=0, sdr_req=0, sdr_addr=0, busy=0. All 4 line valid bits and all tags are cleared. Fill state goes to IDLE.
- Line store per channel c (0..3): valid[c], tag[c][16:0] = addr[19:3], data[c][63:0].
- Lookup, latency 1: in cycle N, let ch = sample_index[2:1].
  - Hit when sample_rd & valid[ch] & tag[ch]==sample_addr[19:3].
  - On hit, cycle N+1 has sample_valid=1 and sample_din = data[ch] byte sample_addr[2:0].
  - On miss, or when sample_rd=0, cycle N+1 has sample_valid=0. sample_din holds its last value.
- Fill FSM states: IDLE, REQ.
  - IDLE -> REQ on a lookup miss with sample_rd=1, provided invalidate is not asserted that cycle. On entry, latch fch=ch and ftag=sample_addr[19:3]. Set sdr_addr = SDR_BASE + {ftag,3'b000} and sdr_req=1.
  - REQ: sdr_req and sdr_addr are held stable. On sdr_rdy: write data[fch]=sdr_data, tag[fch]=ftag, valid[fch]=1; drop sdr_req; go to IDLE.
  - sdr_rdy while IDLE is ignored.
- Misses from any channel while in REQ are not queued. The GA20 core re-presents every channel every 8 steps, so the miss retries naturally.
- The next fill may start in the cycle after returning to IDLE.
- A fill completing in the same cycle as a lookup to the same channel: the lookup uses the pre-write contents. If that lookup misses, sample_valid=0 next cycle and no new fill starts that cycle.
- invalidate:
  - Clears all valid bits in the same cycle.
  - An in-flight fill still completes its handshake but its data is discarded (valid not set).
  - A lookup in the same cycle as invalidate returns sample_valid=0.
- Tag replacement is per channel only. Channel c never evicts channel d's line.
- Address arithmetic: SDR_BASE + offset truncated to SDR_AW bits, wrap-around allowed.
- Reset mid-fill returns to IDLE with sdr_req=0 immediately. A late sdr_rdy after reset is ignored.

Optional Feature:
- Macro GA20_FETCH_STATS_EN.
- With the macro defined, add two output ports `hit_count` and `miss_count`, each 16 bits.
  - They count lookups with sample_rd=1 that hit or miss respectively.
  - They saturate at 16'hFFFF, reset to 0, and also clear on invalidate.
- Without the macro, the ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- Cold miss, SDR_BASE=25'h100000: idx=2, addr=20'h12345 -> sample_valid=0 next cycle. Then sdr_req=1 with sdr_addr=25'h112340. Return sdr_rdy with data 64'h0807060504030201, then re-request -> sample_valid=1, sample_din=8'h06.
- Hit streaming: after the fill above, addrs 20'h12340..12347 on idx 3 -> each returns bytes 01..08 with latency 1.
- Channel isolation: fill ch0 line 20'h00000 and ch1 line 20'h00008, then re-request ch0 -> hit, with no sdr_req asserted.
- Busy conflict: ch1 miss while a ch0 fill is in REQ -> sample_valid=0 and no second sdr_req. After ch0 completes, the next ch1 request starts a fill for ch1's address.
- Invalidate during REQ, then sdr_rdy -> the same address still misses and a new fill issues.
- Reset asserted while sdr_req=1 -> sdr_req=0 the next cycle. A later sdr_rdy produces no line write and a subsequent lookup misses. With GA20_FETCH_STATS_EN, the counters read 0 after reset.

Source files
------------

// File: rtl/ga20_sample_fetch_if.sv
// ga20_sample_fetch_if: GA20 sample-ROM read port bundled with the SDRAM line-fill handshake.
interface ga20_sample_fetch_if #(parameter int SDR_AW = 25);
    logic              sample_rd;
    logic [2:0]        sample_index;
    logic [19:0]       sample_addr;
    logic              sample_valid;
    logic [7:0]        sample_din;
    logic              sdr_req;
    logic [SDR_AW-1:0] sdr_addr;
    logic              sdr_rdy;
    logic [63:0]       sdr_data;
    modport master (
        output sample_rd, sample_index, sample_addr, sdr_rdy, sdr_data,
        input  sample_valid, sample_din, sdr_req, sdr_addr
    );
    modport slave (
        input  sample_rd, sample_index, sample_addr, sdr_rdy, sdr_data,
        output sample_valid, sample_din, sdr_req, sdr_addr
    );
endinterface

// File: rtl/ga20_sample_fetch.sv
// ga20_sample_fetch: one 8-byte line per GA20 channel, refilled from SDRAM one line at a time.
// Define GA20_FETCH_STATS_EN to add saturating hit_count/miss_count outputs.
module ga20_sample_fetch #(
    parameter int                SDR_AW   = 25,
    parameter logic [SDR_AW-1:0] SDR_BASE = '0
) (
    input  logic               clk,
    input  logic               reset,
    ga20_sample_fetch_if.slave bus,
    input  logic               invalidate,
    output logic               busy
`ifdef GA20_FETCH_STATS_EN
    ,
    output logic [15:0]        hit_count,
    output logic [15:0]        miss_count
`endif
);
    typedef enum logic {IDLE, REQ} state_t;
    state_t      state, state_nx;
    logic [3:0]  valid;
    logic [16:0] tag [4];
    logic [63:0] data [4];
    logic [1:0]  ch, fch;
    logic [16:0] ftag;
    logic        fdrop;
    logic        hit, start, done;
    logic        unused_idx0;

    assign unused_idx0 = bus.sample_index[0];
    assign ch          = bus.sample_index[2:1];
    assign hit         = bus.sample_rd && valid[ch] && tag[ch] == bus.sample_addr[19:3];
    assign busy        = state == REQ;
    assign bus.sdr_req = state == REQ;

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        done     = 1'b0;
        if (state == IDLE) begin
            start    = bus.sample_rd && !hit && !invalidate;
            state_nx = start ? REQ : IDLE;
        end else begin
            done     = bus.sdr_rdy;
            state_nx = done ? IDLE : REQ;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            valid            <= '0;
            for (int i = 0; i < 4; i++) tag[i] <= '0;
            bus.sample_valid <= 1'b0;
            bus.sample_din   <= '0;
            bus.sdr_addr     <= '0;
            fch              <= '0;
            ftag             <= '0;
            fdrop            <= 1'b0;
        end else begin
            state            <= state_nx;
            bus.sample_valid <= hit && !invalidate;
            if (hit && !invalidate) bus.sample_din <= data[ch][{bus.sample_addr[2:0], 3'b000} +: 8];
            if (start) begin
                fch          <= ch;
                ftag         <= bus.sample_addr[19:3];
                fdrop        <= 1'b0;
                bus.sdr_addr <= SDR_BASE + SDR_AW'({bus.sample_addr[19:3], 3'b000});
            end else if (invalidate) begin
                fdrop <= 1'b1;
            end
            if (done) tag[fch] <= ftag;
            // A fill invalidated while in flight still completes the handshake but stays invalid.
            if (invalidate) valid <= '0;
            else if (done && !fdrop) valid[fch] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (done) data[fch] <= bus.sdr_data;
    end

`ifdef GA20_FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (reset || invalidate) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (bus.sample_rd) begin
            if (hit) hit_count <= (hit_count == 16'hFFFF) ? hit_count : hit_count + 16'd1;
            else miss_count <= (miss_count == 16'hFFFF) ? miss_count : miss_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ga20_sample_fetch.sv
// tb_ga20_sample_fetch: directed test-plan scenarios plus random traffic against a line-cache reference model.
module tb_ga20_sample_fetch;
    localparam logic [24:0] BASE = 25'h100000;
    logic clk = 1'b0;
    logic reset, invalidate, busy;
`ifdef GA20_FETCH_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif
    ga20_sample_fetch_if #(.SDR_AW(25)) bus();
    ga20_sample_fetch #(.SDR_AW(25), .SDR_BASE(BASE)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .invalidate(invalidate),
        .busy(busy)
`ifdef GA20_FETCH_STATS_EN
        ,
        .hit_count(hit_count),
        .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    // reference model: per-channel line store plus one pending fill
    bit          m_val [4];
    int          m_line [4];
    logic [63:0] m_dat [4];
    bit          m_pend, m_drop;
    int          m_pch, m_pline;
    logic [24:0] m_addr;
    bit          e_valid;
    logic [7:0]  e_din;
    int          m_hits, m_miss;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit rd, input int idx, input int a, input bit inv,
                        input bit rdy, input logic [63:0] d, input bit rs);
        bus.sample_rd    = rd;
        bus.sample_index = 3'(idx);
        bus.sample_addr  = 20'(a);
        invalidate       = inv;
        bus.sdr_rdy      = rdy;
        bus.sdr_data     = d;
        reset            = rs;
        if (rs) begin
            for (int i = 0; i < 4; i++) begin
                m_val[i]  = 0;
                m_line[i] = 0;
            end
            m_pend  = 0;
            m_drop  = 0;
            m_addr  = '0;
            e_valid = 0;
            e_din   = '0;
            m_hits  = 0;
            m_miss  = 0;
        end else begin
            int c        = idx / 2;
            int line     = a / 8;
            bit lhit     = rd && m_val[c] && m_line[c] == line;
            bit was_idle = !m_pend;
            e_valid = lhit && !inv;
            if (e_valid) e_din = 8'(m_dat[c] >> (8 * (a % 8)));
            if (m_pend && rdy) begin
                m_dat[m_pch]  = d;
                m_line[m_pch] = m_pline;
                if (!m_drop) m_val[m_pch] = 1;
                m_pend = 0;
            end
            if (was_idle && rd && !lhit && !inv) begin
                m_pend  = 1;
                m_pch   = c;
                m_pline = line;
                m_drop  = 0;
                m_addr  = 25'(BASE + 25'(line * 8));
            end
            if (inv) begin
                for (int i = 0; i < 4; i++) m_val[i] = 0;
                m_drop = 1;
                m_hits = 0;
                m_miss = 0;
            end else if (rd) begin
                if (lhit) m_hits = (m_hits < 65535) ? m_hits + 1 : m_hits;
                else m_miss = (m_miss < 65535) ? m_miss + 1 : m_miss;
            end
        end
        @(posedge clk);
        #1;
        check("sample_valid", 64'(bus.sample_valid), 64'(e_valid));
        check("sample_din", 64'(bus.sample_din), 64'(e_din));
        check("sdr_req", 64'(bus.sdr_req), 64'(m_pend));
        check("busy", 64'(busy), 64'(m_pend));
        check("sdr_addr", 64'(bus.sdr_addr), 64'(m_addr));
`ifdef GA20_FETCH_STATS_EN
        check("hit_count", 64'(hit_count), 64'(m_hits));
        check("miss_count", 64'(miss_count), 64'(m_miss));
`endif
    endtask

    task automatic lookup(input int idx, input int a);
        step(1, idx, a, 0, 0, '0, 0);
    endtask

    task automatic fill(input logic [63:0] d);
        step(0, 0, 0, 0, 1, d, 0);
    endtask

    initial begin
        step(0, 0, 0, 0, 0, '0, 1);
        step(0, 0, 0, 0, 0, '0, 1);
        check("reset_valid", 64'(bus.sample_valid), 64'd0);
        check("reset_req", 64'(bus.sdr_req), 64'd0);
        // cold miss and fill
        lookup(2, 20'h12345);
        check("cold_miss_valid", 64'(bus.sample_valid), 64'd0);
        check("cold_req", 64'(bus.sdr_req), 64'd1);
        check("cold_addr", 64'(bus.sdr_addr), 64'h112340);
        step(0, 0, 0, 0, 0, '0, 0);
        check("req_held", 64'(bus.sdr_req), 64'd1);
        fill(64'h0807060504030201);
        check("req_drop", 64'(bus.sdr_req), 64'd0);
        lookup(2, 20'h12345);
        check("refetch_valid", 64'(bus.sample_valid), 64'd1);
        check("refetch_din", 64'(bus.sample_din), 64'h06);
        // hit streaming on the other idx of the same channel
        for (int k = 0; k < 8; k++) begin
            lookup(3, 20'h12340 + k);
            check("stream_din", 64'(bus.sample_din), 64'(k + 1));
        end
        // channel isolation
        lookup(0, 20'h00000);
        fill({$urandom, $urandom});
        lookup(2, 20'h00008);
        fill({$urandom, $urandom});
        lookup(0, 20'h00003);
        check("iso_hit", 64'(bus.sample_valid), 64'd1);
        check("iso_noreq", 64'(bus.sdr_req), 64'd0);
        // busy conflict
        lookup(0, 20'h00040);
        lookup(2, 20'h00080);
        check("conflict_valid", 64'(bus.sample_valid), 64'd0);
        check("conflict_addr", 64'(bus.sdr_addr), 64'h100040);
        fill({$urandom, $urandom});
        lookup(2, 20'h00080);
        check("second_fill_addr", 64'(bus.sdr_addr), 64'h100080);
        fill({$urandom, $urandom});
        // invalidate during REQ
        lookup(4, 20'h00200);
        step(0, 0, 0, 1, 0, '0, 0);
        fill({$urandom, $urandom});
        lookup(4, 20'h00200);
        check("inval_miss", 64'(bus.sample_valid), 64'd0);
        check("inval_refill", 64'(bus.sdr_req), 64'd1);
        fill({$urandom, $urandom});
        lookup(4, 20'h00201);
        check("inval_after", 64'(bus.sample_valid), 64'd1);
        // reset mid-fill, then a late sdr_rdy
        lookup(6, 20'h00300);
        step(0, 0, 0, 0, 0, '0, 1);
        check("reset_drop_req", 64'(bus.sdr_req), 64'd0);
        fill({$urandom, $urandom});
        lookup(6, 20'h00300);
        check("late_rdy_miss", 64'(bus.sample_valid), 64'd0);
        fill({$urandom, $urandom});
        // random traffic
        for (int n = 0; n < 3000; n++) begin
            int a = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 20'hFFFFF))
                                                : int'($urandom_range(0, 5)) * 8248 + int'($urandom_range(0, 7));
            bit rdy = m_pend ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            step($urandom_range(0, 9) < 8, $urandom_range(0, 7), a, $urandom_range(0, 63) == 0,
                 rdy, {$urandom, $urandom}, $urandom_range(0, 499) == 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
